// File: rtl/circ_q_share_ctrl.sv
// Arbitrates NUM_REQ producers onto one circ_q and sequences consumer reads,
// tracking each stored word's source in a shadow tag FIFO and supporting a flush/drain.
module circ_q_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DEPTH   = 2,
    parameter int WORD_SZ = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WORD_SZ-1:0] req_data,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       pop_req,
    output logic                       pop_valid,
    output logic [WORD_SZ-1:0]         pop_data,
    output logic [ID_W-1:0]            pop_src,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       q_wr,
    output logic                       q_rd,
    output logic [WORD_SZ-1:0]         q_data_in,
    input  logic [WORD_SZ-1:0]         q_data_out,
    input  logic                       q_full,
    input  logic                       q_empty,
    output logic                       err
);

    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [RR_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]   tag_wr_ptr_reg, tag_rd_ptr_reg;
    logic [ID_W-1:0]    tag_mem [DEPTH];
    logic [ID_W-1:0]    pop_src_reg;
    logic               pop_valid_reg;
    logic               rd_out_reg;
    logic               wr_last_reg;
    logic               err_reg;

    logic [WORD_SZ-1:0] req_word [NUM_REQ];
    logic               grant_any;
    logic [RR_W-1:0]    grant_idx;
    logic [RR_W-1:0]    scan_idx;
    logic               wr_en;
    logic               rd_en;
    logic               flag_mismatch;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_word[gi] = req_data[gi*WORD_SZ +: WORD_SZ];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan: first requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = RR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!grant_any && req[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // The local count is authoritative; queue flags only feed the consistency monitor.
    assign wr_en = rst && (state_reg == ST_RUN) && (count_reg < DEPTH_C) && grant_any;
    assign rd_en = rst && (count_reg != '0) && (pop_req || (state_reg == ST_DRAIN));

    assign gnt        = wr_en ? (NUM_REQ'(1) << grant_idx) : '0;
    assign q_wr       = wr_en;
    assign q_rd       = rd_en;
    assign q_data_in  = wr_en ? req_word[grant_idx] : '0;
    assign pop_valid  = rst && pop_valid_reg;
    assign pop_data   = pop_valid ? q_data_out : '0;
    assign pop_src    = rst ? pop_src_reg : '0;
    assign flush_done = rst && (state_reg == ST_DONE);
    assign err        = rst && err_reg;

    assign flag_mismatch = ((count_reg == DEPTH_C) != q_full) ||
                           ((count_reg == '0) != q_empty);

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (wr_en) begin
            rr_ptr_next = (grant_idx == RR_LAST) ? '0 : grant_idx + 1'b1;
        end
    end

    // Drain finishes only once the last read's data has come back from the queue.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (flush) state_next = ST_DRAIN;
            ST_DRAIN: if ((count_reg == '0) && !rd_out_reg) state_next = ST_DONE;
            ST_DONE:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[tag_wr_ptr_reg] <= ID_W'(grant_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_RUN;
            count_reg      <= '0;
            rr_ptr_reg     <= '0;
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
            pop_src_reg    <= '0;
            pop_valid_reg  <= 1'b0;
            rd_out_reg     <= 1'b0;
            wr_last_reg    <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rr_ptr_reg    <= rr_ptr_next;
            if (wr_en) begin
                tag_wr_ptr_reg <= ptr_inc(tag_wr_ptr_reg);
            end
            if (rd_en) begin
                tag_rd_ptr_reg <= ptr_inc(tag_rd_ptr_reg);
                pop_src_reg    <= tag_mem[tag_rd_ptr_reg];
            end
            pop_valid_reg <= rd_en && (state_reg == ST_RUN);
            rd_out_reg    <= rd_en;
            wr_last_reg   <= wr_en;
            // Combined read+write cycles leave the flags ambiguous, so only one-sided updates are judged.
            if ((wr_last_reg ^ rd_out_reg) && flag_mismatch) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_circ_q_share_ctrl.sv
// Bench for circ_q_share_ctrl: a behavioural circ_q plus a queue-based reference
// model of the shared controller, driven by directed and randomized scenarios.
module tb_circ_q_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DEPTH   = 2;
    localparam int WORD_SZ = 32;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ*WORD_SZ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]         gnt;
    logic                       pop_req = 1'b0;
    logic                       pop_valid;
    logic [WORD_SZ-1:0]         pop_data;
    logic [ID_W-1:0]            pop_src;
    logic                       flush = 1'b0;
    logic                       flush_done;
    logic                       q_wr, q_rd;
    logic [WORD_SZ-1:0]         q_data_in;
    logic [WORD_SZ-1:0]         q_data_out;
    logic                       q_full, q_empty;
    logic                       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    circ_q_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DEPTH(DEPTH), .WORD_SZ(WORD_SZ)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data), .pop_src(pop_src),
        .flush(flush), .flush_done(flush_done), .q_wr(q_wr), .q_rd(q_rd),
        .q_data_in(q_data_in), .q_data_out(q_data_out), .q_full(q_full),
        .q_empty(q_empty), .err(err)
    );

    // Behavioural circ_q (its reset is the inverse of rst).
    logic [WORD_SZ-1:0] cq_mem [DEPTH];
    int cq_wp, cq_rp, cq_cnt;
    always @(posedge clk) begin
        if (!rst) begin
            cq_wp <= 0; cq_rp <= 0; cq_cnt <= 0; q_data_out <= '0;
        end else begin
            if (q_wr) begin
                cq_mem[cq_wp] <= q_data_in;
                cq_wp <= (cq_wp + 1) % DEPTH;
            end
            if (q_rd) begin
                q_data_out <= cq_mem[cq_rp];
                cq_rp <= (cq_rp + 1) % DEPTH;
            end
            cq_cnt <= cq_cnt + int'(q_wr) - int'(q_rd);
        end
    end
    assign q_full  = (cq_cnt == DEPTH);
    assign q_empty = (cq_cnt == 0);

    // Reference model: stored words and sources in queues, mode 0=RUN 1=DRAIN 2=DONE.
    logic [WORD_SZ-1:0] mq_data[$];
    int                 mq_src[$];
    int                 m_rr, m_mode, m_ps;
    bit                 m_rd_last, m_pv;
    logic [WORD_SZ-1:0] m_pd;

    logic [NUM_REQ-1:0] e_gnt;
    logic [WORD_SZ-1:0] e_din;
    bit                 e_wr, e_rd, e_pv, e_fd;
    int                 e_idx;

    function automatic void predict();
        bit found = 0;
        e_gnt = '0; e_din = '0; e_wr = 0; e_rd = 0; e_idx = 0;
        if (rst) begin
            if (m_mode == 0 && mq_data.size() < DEPTH) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int i = (m_rr + k) % NUM_REQ;
                    if (!found && req[i]) begin
                        found = 1; e_idx = i; e_wr = 1;
                        e_gnt[i] = 1'b1;
                        e_din = req_data[i*WORD_SZ +: WORD_SZ];
                    end
                end
            end
            e_rd = (mq_data.size() > 0) && (pop_req || m_mode == 1);
        end
        e_pv = rst && m_pv;
        e_fd = rst && (m_mode == 2);
    endfunction

    task automatic sample();
        @(negedge clk);
        predict();
    endtask

    task automatic adv();
        int nm;
        @(posedge clk);
        if (!rst) begin
            mq_data.delete(); mq_src.delete();
            m_rr = 0; m_mode = 0; m_rd_last = 0; m_pv = 0; m_pd = '0; m_ps = 0;
        end else begin
            nm = m_mode;
            case (m_mode)
                0: if (flush) nm = 1;
                1: if (mq_data.size() == 0 && !m_rd_last) nm = 2;
                default: nm = 0;
            endcase
            m_pv = 0;
            if (e_rd) begin
                m_pd = mq_data.pop_front();
                m_ps = mq_src.pop_front();
                m_pv = (m_mode == 0);
            end
            if (e_wr) begin
                mq_data.push_back(e_din);
                mq_src.push_back(e_idx);
                m_rr = (e_idx + 1) % NUM_REQ;
            end
            m_rd_last = e_rd;
            m_mode = nm;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; req = '1; pop_req = 1'b1; flush = 1'b0;
        repeat (3) begin sample(); adv(); end
        rst = 1'b1; req = '0; pop_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'hF; pop_req = 1'b1; flush = 1'b0;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            sample();
            checks++;
            if ({gnt, q_wr, q_rd, pop_valid, flush_done, err} !== '0 || q_data_in !== '0 ||
                pop_data !== '0 || pop_src !== '0) begin
                errors++;
                $display("FAIL reset cyc=%0d gnt=%h q_wr=%b q_rd=%b pv=%b fd=%b err=%b din=%h pd=%h ps=%0d required all 0",
                         c, gnt, q_wr, q_rd, pop_valid, flush_done, err, q_data_in, pop_data, pop_src);
            end
            adv();
        end
        rst = 1'b1; req = '0; pop_req = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_rr_fairness();
        logic [WORD_SZ-1:0] word [NUM_REQ];
        logic [NUM_REQ-1:0] one = 4'b0001;
        int gk = 0, pk = 0;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            word[i] = $urandom;
            req_data[i*WORD_SZ +: WORD_SZ] = word[i];
        end
        req = 4'hF; pop_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            sample();
            if (gnt !== '0) begin
                checks++;
                if (gnt !== (one << (gk % NUM_REQ))) begin
                    errors++;
                    $display("FAIL rr_gnt n=%0d got=%b required=%b", gk, gnt, one << (gk % NUM_REQ));
                end
                gk++;
            end
            if (pop_valid) begin
                checks++;
                if (pop_src !== ID_W'(pk % NUM_REQ) || pop_data !== word[pk % NUM_REQ]) begin
                    errors++;
                    $display("FAIL rr_pop n=%0d src=%0d data=%h required src=%0d data=%h",
                             pk, pop_src, pop_data, pk % NUM_REQ, word[pk % NUM_REQ]);
                end
                pk++;
            end
            adv();
        end
        checks++;
        if (gk < 10 || pk < 9) begin
            errors++;
            $display("FAIL rr_count grants=%0d pops=%0d required >=10 and >=9", gk, pk);
        end
        req = '0; pop_req = 1'b0;
        $display("test_rr_fairness grants=%0d pops=%0d", gk, pk);
    endtask

    task automatic test_full();
        int d = 0, g = 0;
        apply_reset();
        req = 4'h1; pop_req = 1'b0;
        req_data[WORD_SZ-1:0] = 32'hA0;
        for (int c = 0; c < 5; c++) begin
            sample();
            if (g == 2) begin
                checks++;
                if (q_wr !== 1'b0 || gnt !== '0) begin
                    errors++;
                    $display("FAIL full_nowr cyc=%0d q_wr=%b gnt=%b required 0", c, q_wr, gnt);
                end
            end
            if (gnt[0]) g++;
            adv();
            if (g > d) begin d = g; req_data[WORD_SZ-1:0] = 32'hA0 + WORD_SZ'(d); end
        end
        checks++;
        if (g !== 2) begin errors++; $display("FAIL full_grants got=%0d required=2", g); end
        pop_req = 1'b1;
        sample();
        checks++;
        if (q_rd !== 1'b1 || q_wr !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_nobypass q_rd=%b q_wr=%b required 1 0", q_rd, q_wr);
        end
        adv();
        pop_req = 1'b0;
        sample();
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 32'hA0 || pop_src !== 2'd0 ||
            gnt !== 4'b0001 || q_data_in !== 32'hA2) begin
            errors++;
            $display("FAIL full_after pv=%b data=%h src=%0d gnt=%b din=%h required 1 a0 0 0001 a2",
                     pop_valid, pop_data, pop_src, gnt, q_data_in);
        end
        adv();
        req = '0;
        $display("test_full grants=%0d", g);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        req = 4'h4; req_data[2*WORD_SZ +: WORD_SZ] = 32'h11; pop_req = 1'b0;
        sample();
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL sim_first gnt=%b required=0100", gnt); end
        adv();
        req_data[2*WORD_SZ +: WORD_SZ] = 32'h22; pop_req = 1'b1;
        sample();
        checks++;
        if (q_wr !== 1'b1 || q_rd !== 1'b1) begin
            errors++;
            $display("FAIL sim_both q_wr=%b q_rd=%b required 1 1", q_wr, q_rd);
        end
        adv();
        req = '0;
        sample();
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 32'h11 || pop_src !== 2'd2 || q_rd !== 1'b1) begin
            errors++;
            $display("FAIL sim_oldest pv=%b data=%h src=%0d q_rd=%b required 1 11 2 1",
                     pop_valid, pop_data, pop_src, q_rd);
        end
        adv();
        pop_req = 1'b0;
        sample();
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 32'h22 || q_rd !== 1'b0) begin
            errors++;
            $display("FAIL sim_second pv=%b data=%h q_rd=%b required 1 22 0", pop_valid, pop_data, q_rd);
        end
        adv();
        $display("test_simultaneous done");
    endtask

    task automatic test_wrap();
        int k = 0, pk = 0;
        apply_reset();
        req = 4'h1; pop_req = 1'b1; req_data[WORD_SZ-1:0] = '0;
        for (int c = 0; c < 40 && pk < 10; c++) begin
            sample();
            if (pop_valid) begin
                checks++;
                if (pop_data !== WORD_SZ'(pk)) begin
                    errors++;
                    $display("FAIL wrap_order n=%0d got=%h required=%h", pk, pop_data, pk);
                end
                pk++;
            end
            if (gnt[0]) begin
                adv();
                k++;
                if (k >= 10) req = '0;
                req_data[WORD_SZ-1:0] = WORD_SZ'(k);
            end else begin
                adv();
            end
        end
        checks++;
        if (pk !== 10 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end pops=%0d err=%b required 10 0", pk, err);
        end
        req = '0; pop_req = 1'b0;
        $display("test_wrap pops=%0d", pk);
    endtask

    task automatic test_flush();
        int gn = 0, rds = 0, pvs = 0, fd = 0;
        apply_reset();
        req = 4'h1; req_data = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) begin sample(); adv(); end
        req = 4'h3; flush = 1'b1;
        sample();
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL flush_full gnt=%b required=0", gnt); end
        adv();
        flush = 1'b0;
        for (int c = 0; c < 20 && fd == 0; c++) begin
            sample();
            if (gnt !== '0) gn++;
            if (q_rd) rds++;
            if (pop_valid) pvs++;
            if (flush_done) fd++;
            adv();
        end
        checks++;
        if (gn !== 0 || rds !== 2 || pvs !== 0 || fd !== 1) begin
            errors++;
            $display("FAIL flush_drain gnts=%0d rds=%0d pvs=%0d done=%0d required 0 2 0 1", gn, rds, pvs, fd);
        end
        sample();
        checks++;
        if (gnt !== 4'b0010 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_resume gnt=%b fd=%b required 0010 0", gnt, flush_done);
        end
        adv();
        req = '0;
        $display("test_flush rds=%0d done=%0d", rds, fd);
    endtask

    task automatic test_random();
        int bad = 0;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 79) != 0);
            req      = NUM_REQ'($urandom);
            req_data = {$urandom, $urandom, $urandom, $urandom};
            pop_req  = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            sample();
            checks++;
            if (gnt !== e_gnt || q_wr !== e_wr || q_rd !== e_rd || q_data_in !== e_din ||
                pop_valid !== e_pv || flush_done !== e_fd || err !== 1'b0 ||
                (e_pv && (pop_data !== m_pd || pop_src !== ID_W'(m_ps)))) begin
                errors++; bad++;
                $display("FAIL rand cyc=%0d gnt=%b/%b wr=%b/%b rd=%b/%b din=%h/%h pv=%b/%b pd=%h/%h ps=%0d/%0d fd=%b/%b err=%b/0",
                         c, gnt, e_gnt, q_wr, e_wr, q_rd, e_rd, q_data_in, e_din, pop_valid, e_pv,
                         pop_data, m_pd, pop_src, m_ps, flush_done, e_fd, err);
            end
            adv();
        end
        rst = 1'b1; req = '0; pop_req = 1'b0; flush = 1'b0;
        $display("test_random cycles=600 bad=%0d", bad);
    endtask

    initial begin
        #1;
        test_reset();
        test_rr_fairness();
        test_full();
        test_simultaneous();
        test_wrap();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
